// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh source arbiter:
// header field layout, broadcast match, header stamp and round-robin pick.
package mesh_pkg;

    localparam int NXTJP_W = 8;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int MODE_W  = 1;
    localparam int HDR_W   = NXTJP_W + ROW_W + COL_W + MODE_W;
    localparam int MAX_SRC = 16;

    localparam logic [ROW_W-1:0] BCAST_ROW = '1;
    localparam logic [COL_W-1:0] BCAST_COL = '1;

    typedef struct packed {
        logic [NXTJP_W-1:0] nxtjp;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [MODE_W-1:0]  mode;
    } hdr_t;

    function automatic logic [ROW_W-1:0] hdr_row(input hdr_t h);
        return h.row;
    endfunction

    function automatic logic [COL_W-1:0] hdr_col(input hdr_t h);
        return h.col;
    endfunction

    function automatic logic is_bcast(input hdr_t h);
        return (h.row == BCAST_ROW) && (h.col == BCAST_COL);
    endfunction

    function automatic hdr_t stamp_src(input hdr_t h, input logic [3:0] idx);
        hdr_t r;
        r       = h;
        r.nxtjp = {{(NXTJP_W-4){1'b0}}, idx};
        return r;
    endfunction

    // First requesting index at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [3:0]         ptr,
        input int unsigned        n
    );
        logic [3:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[3:0]]) begin
                win   = idx[3:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mesh_src_arbiter_if.sv
// Bundle of the per-source push side and the merged mesh output lane.
// slave = arbiter side, master = sources/consumer side.
interface mesh_src_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int pckg_sz = 20,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC-1:0] push;
    logic [pckg_sz-1:0] data_in [NUM_SRC];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] ovf;
    logic               pndng;
    logic [pckg_sz-1:0] data_out;
    logic               popin;
    logic [CNT_W-1:0]   pkt_cnt;

    modport slave (
        input  push, data_in, popin,
        output full, ovf, pndng, data_out, pkt_cnt
    );

    modport master (
        output push, data_in, popin,
        input  full, ovf, pndng, data_out, pkt_cnt
    );
endinterface

// File: rtl/mesh_fifo.sv
// Per-source packet FIFO with show-ahead read.
// Push while full and pop while empty are ignored.
module mesh_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // Next storage, pointers and occupancy from accepted push/pop.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers, cleared on synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mesh_src_arbiter.sv
// Merges NUM_SRC source FIFOs onto one mesh input lane with a
// round-robin arbiter, optional source stamp, overflow flags and counter.
module mesh_src_arbiter
    import mesh_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int pckg_sz    = 20,
    parameter int fifo_depth = 4,
    parameter int STAMP_SRC  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mesh_src_arbiter_if.slave    bus
);
    localparam int FCW = $clog2(fifo_depth) + 1;

    logic [pckg_sz-1:0] fifo_dout [NUM_SRC];
    logic [FCW-1:0]     fifo_cnt  [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_full, fifo_empty, pop;

    logic               pndng_q, pndng_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [NUM_SRC-1:0] at_cap;

    logic [MAX_SRC-1:0] req;
    logic [3:0]         win;
    logic [pckg_sz-1:0] pkt;
    logic               load;
    int unsigned        nxt;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        mesh_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (bus.push[k]),
            .pop   (pop[k]),
            .din   (bus.data_in[k]),
            .dout  (fifo_dout[k]),
            .full  (fifo_full[k]),
            .empty (fifo_empty[k]),
            .count (fifo_cnt[k])
        );
        assign at_cap[k] = (fifo_cnt[k] == FCW'(fifo_depth));
    end

    assign bus.full     = fifo_full;
    assign bus.ovf      = ovf_q;
    assign bus.pndng    = pndng_q;
    assign bus.data_out = data_q;
    assign bus.pkt_cnt  = cnt_q;

    // Arbitration, output-register load, overflow and counter updates.
    always_comb begin
        req                = '0;
        req[NUM_SRC-1:0]   = ~fifo_empty;
        load               = !pndng_q || bus.popin;
        win                = rr_pick(req, ptr_q, NUM_SRC);
        nxt                = (32'(win) + 1) % NUM_SRC;
        pop                = '0;
        pkt                = '0;
        pndng_d            = pndng_q;
        data_d             = data_q;
        ptr_d              = ptr_q;
        ovf_d              = ovf_q | (bus.push & at_cap);
        cnt_d              = cnt_q + CNT_W'(pndng_q && bus.popin);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (4'(k) == win) pkt = fifo_dout[k];
        end
        if (STAMP_SRC != 0) begin
            pkt[pckg_sz-1 -: HDR_W] =
                stamp_src(hdr_t'(pkt[pckg_sz-1 -: HDR_W]), win);
        end
        if (load) begin
            if (|req) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (4'(k) == win) pop[k] = 1'b1;
                end
                pndng_d = 1'b1;
                data_d  = pkt;
                ptr_d   = nxt[3:0];
            end else begin
                pndng_d = 1'b0;
            end
        end
    end

    // Output stage and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pndng_q <= 1'b0;
            data_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else begin
            pndng_q <= pndng_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mesh_src_arbiter.sv
// Directed bench for mesh_src_arbiter: expected packets go into
// per-DUT queues and a monitor compares them as they are consumed.
module tb_mesh_src_arbiter;
    localparam int NS = 4;
    localparam int PW = 20;
    localparam int CW = 16;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [PW-1:0] q0 [$];
    logic [PW-1:0] q1 [$];

    mesh_src_arbiter_if #(.NUM_SRC(NS), .pckg_sz(PW), .CNT_W(CW)) a_if ();
    mesh_src_arbiter_if #(.NUM_SRC(NS), .pckg_sz(PW), .CNT_W(CW)) b_if ();

    mesh_src_arbiter #(
        .NUM_SRC(NS), .pckg_sz(PW), .fifo_depth(4),
        .STAMP_SRC(1), .CNT_W(CW)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    mesh_src_arbiter #(
        .NUM_SRC(NS), .pckg_sz(PW), .fifo_depth(4),
        .STAMP_SRC(0), .CNT_W(CW)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every consumed beat must match the head of its queue.
    initial begin
        logic [PW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && a_if.pndng && a_if.popin) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL a_out: got %h, expected none",
                             a_if.data_out);
                end else begin
                    exp = q0.pop_front();
                    if (a_if.data_out !== exp) begin
                        errors++;
                        $display("FAIL a_out: got %h, expected %h",
                                 a_if.data_out, exp);
                    end
                end
            end
            if (!reset && b_if.pndng && b_if.popin) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL b_out: got %h, expected none",
                             b_if.data_out);
                end else begin
                    exp = q1.pop_front();
                    if (b_if.data_out !== exp) begin
                        errors++;
                        $display("FAIL b_out: got %h, expected %h",
                                 b_if.data_out, exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [PW-1:0] d;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a_if.push  = '0;
        a_if.popin = 1'b0;
        b_if.push  = '0;
        b_if.popin = 1'b0;
        for (int k = 0; k < NS; k++) begin
            a_if.data_in[k] = '0;
            b_if.data_in[k] = '0;
        end
        tick();
        do_reset();

        // Reset state
        chk("rst_pndng", 32'(a_if.pndng), 32'h0);
        chk("rst_data", 32'(a_if.data_out), 32'h0);
        chk("rst_full", 32'(a_if.full), 32'h0);
        chk("rst_ovf", 32'(a_if.ovf), 32'h0);
        chk("rst_cnt", 32'(a_if.pkt_cnt), 32'h0);

        // 1: single packet, latency and stamp
        a_if.push[1]    = 1'b1;
        a_if.data_in[1] = 20'h00257;
        tick();
        a_if.push = '0;
        chk("t1_pndng_early", 32'(a_if.pndng), 32'h0);
        tick();
        chk("t1_pndng", 32'(a_if.pndng), 32'h1);
        chk("t1_data", 32'(a_if.data_out), 32'h01257);
        q0.push_back(20'h01257);
        a_if.popin = 1'b1;
        tick();
        a_if.popin = 1'b0;
        chk("t1_pndng_after", 32'(a_if.pndng), 32'h0);
        chk("t1_cnt", 32'(a_if.pkt_cnt), 32'h1);

        // 2: all sources at once, full throughput in order 0..3
        do_reset();
        for (int k = 0; k < NS; k++) begin
            a_if.push[k]    = 1'b1;
            a_if.data_in[k] = 20'(k + 1);
            q0.push_back({8'(k), 12'(k + 1)});
        end
        a_if.popin = 1'b1;
        tick();
        a_if.push = '0;
        repeat (4) tick();
        chk("t2_cnt_mid", 32'(a_if.pkt_cnt), 32'h3);
        tick();
        chk("t2_cnt", 32'(a_if.pkt_cnt), 32'h4);
        chk("t2_pndng", 32'(a_if.pndng), 32'h0);
        a_if.popin = 1'b0;

        // 3: fairness, src2 slots in ahead of src0's next packet
        do_reset();
        q0.push_back({8'h00, 4'h0, 4'h3, 1'b0, 3'h0});
        q0.push_back({8'h00, 4'h1, 4'h3, 1'b0, 3'h0});
        q0.push_back({8'h02, 4'hA, 4'hB, 1'b1, 3'h5});
        q0.push_back({8'h00, 4'h2, 4'h3, 1'b0, 3'h0});
        q0.push_back({8'h00, 4'h3, 4'h3, 1'b0, 3'h0});
        q0.push_back({8'h00, 4'h4, 4'h3, 1'b0, 3'h0});
        a_if.popin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_if.push[0]    = 1'b1;
            a_if.data_in[0] = {8'h00, 4'(i), 4'h3, 1'b0, 3'h0};
            a_if.push[2]    = (i == 2);
            a_if.data_in[2] = {8'h77, 4'hA, 4'hB, 1'b1, 3'h5};
            tick();
        end
        a_if.push = '0;
        repeat (6) tick();
        a_if.popin = 1'b0;
        chk("t3_cnt", 32'(a_if.pkt_cnt), 32'h6);

        // 4: overflow on src3
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = {8'h00, 4'h1, 4'h2, 1'b0, 3'(i)};
            a_if.push[3]    = 1'b1;
            a_if.data_in[3] = d;
            if (i < 5) q0.push_back({8'h03, d[11:0]});
            tick();
            if (i == 4) begin
                chk("t4_full", 32'(a_if.full), 32'h8);
                chk("t4_ovf_pre", 32'(a_if.ovf), 32'h0);
            end
        end
        a_if.push = '0;
        chk("t4_ovf", 32'(a_if.ovf), 32'h8);
        a_if.popin = 1'b1;
        repeat (7) tick();
        a_if.popin = 1'b0;
        chk("t4_ovf_sticky", 32'(a_if.ovf), 32'h8);
        chk("t4_full_after", 32'(a_if.full), 32'h0);
        chk("t4_cnt", 32'(a_if.pkt_cnt), 32'h5);

        // 5: reset with one packet held and two queued
        for (int k = 0; k < 3; k++) begin
            a_if.push[k]    = 1'b1;
            a_if.data_in[k] = 20'hABC00 | 20'(k);
        end
        tick();
        a_if.push = '0;
        tick();
        chk("t5_pndng_pre", 32'(a_if.pndng), 32'h1);
        do_reset();
        chk("t5_pndng", 32'(a_if.pndng), 32'h0);
        chk("t5_ovf", 32'(a_if.ovf), 32'h0);
        chk("t5_cnt", 32'(a_if.pkt_cnt), 32'h0);
        a_if.popin = 1'b1;
        repeat (6) tick();
        a_if.popin = 1'b0;
        chk("t5_quiet", 32'(a_if.pndng), 32'h0);
        chk("t5_cnt_after", 32'(a_if.pkt_cnt), 32'h0);

        // 6: no stamping, broadcast passes bit-identical
        d = {8'h5A, 4'hF, 4'hF, 1'b1, 3'h6};
        b_if.push[2]    = 1'b1;
        b_if.data_in[2] = d;
        q1.push_back(d);
        tick();
        b_if.push = '0;
        tick();
        chk("t6_pndng", 32'(b_if.pndng), 32'h1);
        chk("t6_data", 32'(b_if.data_out), 32'h5AFFE);
        b_if.popin = 1'b1;
        tick();
        b_if.popin = 1'b0;
        chk("t6_cnt", 32'(b_if.pkt_cnt), 32'h1);

        chk("drain_a", 32'(q0.size()), 32'h0);
        chk("drain_b", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
